// File: rtl/mem_pkg.sv
// Shared constants and the state encoding used by the data memory responder.
package mem_pkg;

  localparam int WORD_W              = 32;
  localparam int DEFAULT_DEPTH       = 64;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  // Wide enough for the largest legal stall count (15)
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with one synchronous write port and one registered read
// port. The storage has no reset, so its contents survive a block reset.
module dmem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write when enabled and capture the addressed word every cycle (read-first)
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder for the pipeline Memory stage. An access
// is accepted in IDLE, stalls the pipeline for WAIT_CYCLES cycles and then
// completes with a one-cycle MemDoneM pulse in RESP.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [WORD_W-1:0] ALUOutM,
  input  logic [WORD_W-1:0] WriteDataM,
  output logic [WORD_W-1:0] ReadDataM,
  output logic              MemStallM,
  output logic              MemDoneM,
  output logic              MemErrM
);

  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(4 * DEPTH);

  mem_state_t state;
  mem_state_t state_next;

  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] wdata_q;
  logic              wr_ok_q;
  logic              err_q;

  logic              req;
  logic              in_addr_bad;
  logic              in_err;
  logic              in_wr_ok;
  logic [IDX_W-1:0]  in_idx;

  logic [IDX_W-1:0]  acc_idx;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_wr_ok;
  logic              commit;
  logic [WORD_W-1:0] rd_data;

  // Decode the live request: word index, alignment/range and dual-op errors.
  // A request with both read and write set still writes if the address is good.
  always_comb begin
    req         = MemReadM | MemWriteM;
    in_idx      = ALUOutM[IDX_W+1:2];
    in_addr_bad = (ALUOutM[1:0] != 2'b00) || (ALUOutM >= ADDR_LIMIT);
    in_err      = in_addr_bad || (MemReadM && MemWriteM);
    in_wr_ok    = MemWriteM && !in_addr_bad;
  end

  // Pick the access driving the array: the live inputs while still in IDLE
  // (needed when a one-cycle wait goes straight to RESP), else the latched copy.
  // The write commits only on the edge that enters RESP, and never in reset.
  always_comb begin
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_wr_ok = wr_ok_q;
    if (state == IDLE) begin
      acc_idx   = in_idx;
      acc_wdata = WriteDataM;
      acc_wr_ok = in_wr_ok;
    end
    commit = reset && (state != RESP) && (state_next == RESP) && acc_wr_ok;
  end

  // Next-state logic and the response outputs
  always_comb begin
    state_next = state;
    MemStallM  = 1'b0;
    MemDoneM   = 1'b0;
    MemErrM    = 1'b0;
    ReadDataM  = '0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = (WAIT_CYCLES == 1) ? RESP : WAIT;
          MemStallM  = reset;
        end
      end
      WAIT: begin
        MemStallM = 1'b1;
        if (cnt <= CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
        MemDoneM   = 1'b1;
        MemErrM    = err_q;
        ReadDataM  = err_q ? '0 : rd_data;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; an asynchronous reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latch the accepted access and count down the remaining wait cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      wr_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            cnt     <= CNT_LOAD;
            idx_q   <= in_idx;
            wdata_q <= WriteDataM;
            wr_ok_q <= in_wr_ok;
            err_q   <= in_err;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (commit),
    .waddr (acc_idx),
    .wdata (acc_wdata),
    .raddr (acc_idx),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH=64, WAIT_CYCLES=2).
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM;
  logic        MemDoneM;
  logic        MemErrM;

  logic [31:0] model [64];
  int          vec_count  = 0;
  int          miss_count = 0;

  data_mem_responder #(
    .DEPTH       (64),
    .WAIT_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .MemStallM  (MemStallM),
    .MemDoneM   (MemDoneM),
    .MemErrM    (MemErrM)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever wedges
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One access starting at posedge+1 in IDLE. Inputs are scrambled once the
  // access is accepted to show the latched copy is what completes.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic exp_err, input logic [31:0] exp_rdata,
                               input logic chk_rdata, input string tag);
    int stalls;
    int cycles;
    stalls = 0;
    cycles = 0;
    MemReadM   = rd;
    MemWriteM  = wr;
    ALUOutM    = addr;
    WriteDataM = data;
    #1;
    while (MemStallM === 1'b1 && cycles < 20) begin
      stalls++;
      checkOutput({tag, " done-in-stall"}, {31'b0, MemDoneM}, 32'd0);
      @(posedge clk);
      #1;
      MemReadM   = 1'b0;
      MemWriteM  = 1'b0;
      ALUOutM    = 32'hFFFF_FFF3;
      WriteDataM = 32'hBAD0_BAD0;
      #1;
      cycles++;
    end
    checkOutput({tag, " stall-count"}, 32'(stalls), 32'd2);
    checkOutput({tag, " done"}, {31'b0, MemDoneM}, 32'd1);
    checkOutput({tag, " err"}, {31'b0, MemErrM}, {31'b0, exp_err});
    if (chk_rdata) begin
      checkOutput({tag, " rdata"}, ReadDataM, exp_rdata);
    end
    @(posedge clk);
    #1;
    checkOutput({tag, " done-pulse-end"}, {31'b0, MemDoneM}, 32'd0);
    checkOutput({tag, " rdata-idle"}, ReadDataM, 32'd0);
  endtask

  // Compare every stored word against the bench model
  task automatic checkAllWords(input string tag);
    for (int i = 0; i < 64; i++) begin
      checkOutput($sformatf("%s word%0d", tag, i), dut.u_array.mem[i], model[i]);
    end
  endtask

  initial begin
    int dones;
    reset      = 1'b0;
    MemReadM   = 1'b1;
    MemWriteM  = 1'b0;
    ALUOutM    = 32'h0;
    WriteDataM = 32'h0;

    // Reset holds everything quiet even with a request present
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst stall", {31'b0, MemStallM}, 32'd0);
    checkOutput("rst done",  {31'b0, MemDoneM},  32'd0);
    checkOutput("rst err",   {31'b0, MemErrM},   32'd0);
    checkOutput("rst rdata", ReadDataM,          32'd0);
    MemReadM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Give every word a known value through the normal write path
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b0, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i),
                    1'b0, 32'd0, 1'b0, $sformatf("fill%0d", i));
      model[i] = 32'h1000_0000 + 32'(i);
    end
    checkAllWords("fill");

    // Basic write then read back
    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, "wr 0x10");
    model[4] = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, "rd 0x10");

    // Misaligned read errors out and changes nothing
    applyStimulus(1'b1, 1'b0, 32'h12, 32'h0, 1'b1, 32'd0, 1'b1, "rd 0x12");
    checkAllWords("misaligned");

    // Out-of-range write errors out and changes nothing
    applyStimulus(1'b0, 1'b1, 32'h100, 32'h1234, 1'b1, 32'd0, 1'b1, "wr 0x100");
    checkAllWords("oor");

    // Last valid word and first invalid read address
    applyStimulus(1'b1, 1'b0, 32'hFC, 32'h0, 1'b0, 32'h1000_003F, 1'b1, "rd 0xFC");
    applyStimulus(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'd0, 1'b1, "rd 0x100");

    // Read and write together: write happens, response is an error with no data
    applyStimulus(1'b1, 1'b1, 32'h8, 32'h55, 1'b1, 32'd0, 1'b1, "rdwr 0x8");
    model[2] = 32'h55;
    applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h55, 1'b1, "rd 0x8");

    // Reset in the first WAIT cycle of a write aborts it
    MemWriteM  = 1'b1;
    ALUOutM    = 32'h4;
    WriteDataM = 32'hAA;
    @(posedge clk);
    #1;
    checkOutput("abort in-wait stall", {31'b0, MemStallM}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort stall", {31'b0, MemStallM}, 32'd0);
    checkOutput("abort done",  {31'b0, MemDoneM},  32'd0);
    checkOutput("abort err",   {31'b0, MemErrM},   32'd0);
    checkOutput("abort rdata", ReadDataM,          32'd0);
    @(posedge clk);
    #1;
    checkOutput("abort held stall", {31'b0, MemStallM}, 32'd0);
    checkOutput("abort held done",  {31'b0, MemDoneM},  32'd0);
    MemWriteM = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort word 0x4", dut.u_array.mem[1], 32'h1000_0001);
    applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h1000_0001, 1'b1, "rd 0x4 after abort");

    // Held read request: accept, wait, respond, then accept again at once
    dones     = 0;
    MemReadM  = 1'b1;
    ALUOutM   = 32'h0;
    #1;
    for (int k = 0; k < 12; k++) begin
      checkOutput($sformatf("hold stall c%0d", k), {31'b0, MemStallM},
                  (k % 3 == 2) ? 32'd0 : 32'd1);
      checkOutput($sformatf("hold done c%0d", k), {31'b0, MemDoneM},
                  (k % 3 == 2) ? 32'd1 : 32'd0);
      if (MemDoneM === 1'b1) begin
        dones++;
        checkOutput($sformatf("hold rdata c%0d", k), ReadDataM, 32'h1000_0000);
      end
      if (k == 11) begin
        MemReadM = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("hold done count", 32'(dones), 32'd4);
    checkOutput("hold final idle", {31'b0, MemStallM}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
